tmds_decoder: RTL

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder_if.sv | 22 ++
 rtl/tmds_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder_if.sv
// Symbol-in / decoded-pixel-out bundle for the TMDS decoder.
// The source (master) drives symbols; the decoder (slave) returns decoded results.
interface tmds_decoder_if;
  logic [9:0] tmds_in;
  logic       valid_in;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       valid_out;
  logic       err_out;
  logic       sync_out;

  modport master (
    output tmds_in, valid_in,
    input  data_out, ctrl_out, de_out, valid_out, err_out, sync_out
  );

  modport slave (
    input  tmds_in, valid_in,
    output data_out, ctrl_out, de_out, valid_out, err_out, sync_out
  );
endinterface

// File: rtl/tmds_decoder.sv
// Two-stage TMDS symbol decoder: stage 1 captures the symbol, stage 2 decodes it,
// tracks running disparity and runs the control-symbol lock FSM.
module tmds_decoder #(
  parameter int LOCK_RUN   = 8,
  parameter int DISP_LIMIT = 16
) (
  input  logic          clk_in,
  input  logic          rst_in,
  tmds_decoder_if.slave bus
);

  // Counter must hold +/-(DISP_LIMIT + 10) before the limit check reloads it.
  localparam int CNT_W_MIN = $clog2(DISP_LIMIT + 11) + 1;
  localparam int CNT_W     = (CNT_W_MIN < 7) ? 7 : CNT_W_MIN;
  localparam int RUN_W     = $clog2(LOCK_RUN + 1);

  localparam logic signed [CNT_W-1:0] C_LIM  = CNT_W'(DISP_LIMIT);
  localparam logic signed [CNT_W-1:0] C_TEN  = CNT_W'(10);
  localparam logic        [RUN_W-1:0] C_LOCK = RUN_W'(LOCK_RUN);
  localparam logic        [RUN_W-1:0] C_ONE  = RUN_W'(1);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  logic [9:0]              r_s1_tmds;
  logic                    r_s1_valid;
  logic [7:0]              r_data;
  logic [1:0]              r_ctrl;
  logic                    r_de;
  logic                    r_valid;
  logic                    r_err;
  logic signed [CNT_W-1:0] r_cnt;
  logic [RUN_W-1:0]        r_run;
  state_t                  r_state;

  logic                    w_ctrl_hit;
  logic [1:0]              w_ctrl_code;
  logic [7:0]              w_q;
  logic [7:0]              w_dec;
  logic [3:0]              w_ones;
  logic signed [CNT_W-1:0] w_disp;
  logic signed [CNT_W-1:0] w_sum;
  logic                    w_over;
  logic                    w_err;
  logic signed [CNT_W-1:0] w_cnt_next;
  logic [RUN_W-1:0]        w_run_next;
  state_t                  w_state_next;

  genvar gi;

  always_comb begin
    w_ctrl_hit  = 1'b1;
    w_ctrl_code = 2'b00;
    case (r_s1_tmds)
      10'b1101010100: w_ctrl_code = 2'b00;
      10'b0010101011: w_ctrl_code = 2'b01;
      10'b0101010100: w_ctrl_code = 2'b10;
      10'b1010101011: w_ctrl_code = 2'b11;
      default:        w_ctrl_hit  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR chain.
  assign w_q      = r_s1_tmds[9] ? ~r_s1_tmds[7:0] : r_s1_tmds[7:0];
  assign w_dec[0] = w_q[0];

  generate
    for (gi = 1; gi < 8; gi++) begin : g_dec
      assign w_dec[gi] = r_s1_tmds[8] ? (w_q[gi] ^ w_q[gi-1])
                                      : ~(w_q[gi] ^ w_q[gi-1]);
    end
  endgenerate

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < 10; i++) begin
      w_ones = w_ones + 4'(r_s1_tmds[i]);
    end
  end

  // Symbol disparity in (ones - zeros) units: 2*ones - 10.
  assign w_disp = $signed(CNT_W'({w_ones, 1'b0})) - C_TEN;
  assign w_sum  = r_cnt + w_disp;
  assign w_over = (w_sum > C_LIM) || (w_sum < -C_LIM);
  assign w_err  = r_s1_valid && !w_ctrl_hit && w_over;

  always_comb begin
    w_cnt_next = r_cnt;
    w_run_next = '0;
    if (w_ctrl_hit) begin
      w_cnt_next = '0;
      if ((r_run != '0) && (w_ctrl_code == r_ctrl)) begin
        w_run_next = (r_run == C_LOCK) ? r_run : r_run + C_ONE;
      end else begin
        w_run_next = C_ONE;
      end
    end else begin
      w_cnt_next = w_over ? w_disp : w_sum;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HUNT: begin
        if (r_s1_valid && (w_run_next == C_LOCK)) begin
          w_state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_err) begin
          w_state_next = ST_HUNT;
        end
      end
      default: w_state_next = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1_tmds  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_tmds  <= bus.tmds_in;
      r_s1_valid <= bus.valid_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_data  <= '0;
      r_ctrl  <= '0;
      r_de    <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_run   <= '0;
      r_state <= ST_HUNT;
    end else begin
      r_valid <= r_s1_valid;
      r_err   <= w_err;
      r_state <= w_state_next;
      if (r_s1_valid) begin
        r_data <= w_ctrl_hit ? 8'h00 : w_dec;
        r_ctrl <= w_ctrl_hit ? w_ctrl_code : r_ctrl;
        r_de   <= !w_ctrl_hit;
        r_cnt  <= w_cnt_next;
        r_run  <= w_run_next;
      end
    end
  end

  assign bus.data_out  = r_data;
  assign bus.ctrl_out  = r_ctrl;
  assign bus.de_out    = r_de;
  assign bus.valid_out = r_valid;
  assign bus.err_out   = r_err;
  assign bus.sync_out  = (r_state == ST_LOCKED);

endmodule
